alarm_bank: RTL and testbench

Multi-slot alarm register for the digital watch, replacing the single-alarm register. Holds `num_alarm` independent BCD hour/minute alarm settings with per-slot enable, edits the selected slot from the minute/hour buttons with hold-to-auto-repeat, compares every slot against the running time each second, and drives a ringing output with acknowledge and timeout. Sits between the button debouncers/mode logic and the display mux/buzzer driver.

---
 rtl/alarm_bank.sv | 116 +++++++++++
 tb/tb_alarm_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot BCD alarm register with button auto-repeat and ring control
module alarm_bank #(
  parameter int num_alarm     = 4,
  parameter int sel_width     = 2,
  parameter int hold_delay    = 500,
  parameter int repeat_period = 100,
  parameter int ring_timeout  = 60
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [sel_width-1:0] sel,
  input  logic                 minute_set,
  input  logic                 hour_set,
  input  logic                 enable_toggle,
  input  logic                 stop,
  input  logic                 second_tick,
  input  logic [7:0]           time_hour,
  input  logic [7:0]           time_minute,
  input  logic [7:0]           time_second,
  output logic [7:0]           hour_data,
  output logic [7:0]           minute_data,
  output logic [7:0]           second_data,
  output logic                 enabled,
  output logic [num_alarm-1:0] enable_mask,
  output logic                 ringing,
  output logic [sel_width-1:0] ring_id
);
  localparam int HMAX = hold_delay > repeat_period ? hold_delay : repeat_period;
  localparam int HW = $clog2(HMAX + 1);
  localparam int CW = $clog2(ring_timeout + 1);
  localparam logic [0:0] IDLE = 1'b0, RING = 1'b1;
  logic [7:0] r_hr [num_alarm];
  logic [7:0] r_min [num_alarm];
  logic [num_alarm-1:0] r_en, w_hit;
  logic [1:0] w_btn, w_inc;
  logic [0:0] r_state;
  logic [CW-1:0] r_tcnt;
  logic [sel_width-1:0] r_id, w_mid;
  logic w_match, w_stop_ring;
  function automatic logic [7:0] inc_min(input logic [7:0] v);
    return v[3:0] != 4'd9 ? v + 8'd1 : v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
  endfunction
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    return v == 8'h23 ? 8'h00 : v[3:0] != 4'd9 ? v + 8'd1 : {v[7:4] + 4'd1, 4'd0};
  endfunction
  assign w_btn = {hour_set, minute_set};
  // r_lock keeps a button held through reset from counting as a fresh press
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic r_prev, r_lock;
    logic [HW-1:0] r_hcnt;
    assign w_inc[b] = w_btn[b] & ~r_lock & (~r_prev | r_hcnt == HW'(1));
    always_ff @(posedge clock)
      if (reset) begin
        r_prev <= 1'b0;
        r_lock <= 1'b1;
        r_hcnt <= '0;
      end else begin
        r_prev <= w_btn[b];
        r_lock <= r_lock & w_btn[b];
        r_hcnt <= !w_btn[b] || r_lock ? '0 : !r_prev ? HW'(hold_delay) :
                  r_hcnt == HW'(1) ? HW'(repeat_period) : r_hcnt - 1'b1;
      end
  end
  always_ff @(posedge clock)
    for (int i = 0; i < num_alarm; i++)
      if (reset) begin
        r_hr[i]  <= 8'h00;
        r_min[i] <= 8'h00;
        r_en[i]  <= 1'b0;
      end else if (w_hit[i]) begin
        if (w_inc[0]) r_min[i] <= inc_min(r_min[i]);
        if (w_inc[1]) r_hr[i] <= inc_hr(r_hr[i]);
        if (enable_toggle) r_en[i] <= ~r_en[i];
      end
  // descending scan so the lowest matching slot wins
  always_comb begin
    w_hit = '0;
    w_match = 1'b0;
    w_mid = '0;
    hour_data = 8'h00;
    minute_data = 8'h00;
    enabled = 1'b0;
    for (int i = num_alarm - 1; i >= 0; i--) begin
      w_hit[i] = sel == sel_width'(i);
      if (r_en[i] && r_hr[i] == time_hour && r_min[i] == time_minute) begin
        w_match = 1'b1;
        w_mid = sel_width'(i);
      end
      if (w_hit[i]) begin
        hour_data = r_hr[i];
        minute_data = r_min[i];
        enabled = r_en[i];
      end
    end
  end
  assign second_data = 8'h00;
  assign enable_mask = r_en;
  assign ringing = r_state == RING;
  assign ring_id = r_id;
  assign w_stop_ring = stop | (enable_toggle & sel == r_id & r_en[r_id]);
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= IDLE;
      r_id <= '0;
      r_tcnt <= '0;
    end else if (r_state == IDLE) begin
      if (second_tick && time_second == 8'h00 && w_match) begin
        r_state <= RING;
        r_id <= w_mid;
        r_tcnt <= '0;
      end
    end else if (w_stop_ring || (second_tick && r_tcnt == CW'(ring_timeout - 1)))
      r_state <= IDLE;
    else if (second_tick)
      r_tcnt <= r_tcnt + 1'b1;
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: randomized and directed checks of alarm_bank against a decimal behavioural model
module tb_alarm_bank;
  localparam int NA = 4, SW = 2, HD = 500, RP = 100, RT = 60;
  logic clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] sel = '0;
  logic minute_set = 0, hour_set = 0, enable_toggle = 0, stop = 0, second_tick = 0;
  int th_i = 0, tm_i = 0, ts_i = 0;
  logic [7:0] time_hour, time_minute, time_second, hour_data, minute_data, second_data;
  logic enabled, ringing;
  logic [NA-1:0] enable_mask;
  logic [SW-1:0] ring_id;
  int checks = 0, errors = 0;
  int mh[NA], mm[NA], run[2], m_id, m_tc, s, emask;
  bit men[NA], armed[2], inc[2], btn[2], m_ring, found;

  function automatic logic [7:0] bcd8(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  assign time_hour = bcd8(th_i);
  assign time_minute = bcd8(tm_i);
  assign time_second = bcd8(ts_i);

  alarm_bank #(.num_alarm(NA), .sel_width(SW), .hold_delay(HD), .repeat_period(RP),
               .ring_timeout(RT)) dut (
    .clock(clk), .reset(rst), .sel(sel), .minute_set(minute_set), .hour_set(hour_set),
    .enable_toggle(enable_toggle), .stop(stop), .second_tick(second_tick),
    .time_hour(time_hour), .time_minute(time_minute), .time_second(time_second),
    .hour_data(hour_data), .minute_data(minute_data), .second_data(second_data),
    .enabled(enabled), .enable_mask(enable_mask), .ringing(ringing), .ring_id(ring_id));

  always #5 clk = ~clk;

  task automatic cmp(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model advances on each edge from the sampled inputs, then outputs are compared
  always @(posedge clk) begin
    btn[0] = minute_set;
    btn[1] = hour_set;
    s = int'(sel);
    if (rst) begin
      for (int i = 0; i < NA; i++) begin mh[i] = 0; mm[i] = 0; men[i] = 0; end
      for (int b = 0; b < 2; b++) begin armed[b] = 0; run[b] = -1; end
      m_ring = 0; m_id = 0; m_tc = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        inc[b] = 0;
        if (!btn[b]) begin armed[b] = 1; run[b] = -1; end
        else if (armed[b]) begin
          run[b]++;
          inc[b] = run[b] == 0 || (run[b] >= HD && (run[b] - HD) % RP == 0);
        end
      end
      if (!m_ring) begin
        found = 0;
        if (second_tick && ts_i == 0)
          for (int i = 0; i < NA; i++)
            if (!found && men[i] && mh[i] == th_i && mm[i] == tm_i) begin
              found = 1; m_ring = 1; m_id = i; m_tc = 0;
            end
      end else if (stop) m_ring = 0;
      else if (enable_toggle && s == m_id && men[m_id]) m_ring = 0;
      else if (second_tick) begin
        m_tc++;
        if (m_tc == RT) m_ring = 0;
      end
      if (s < NA) begin
        if (inc[0]) mm[s] = (mm[s] + 1) % 60;
        if (inc[1]) mh[s] = (mh[s] + 1) % 24;
        if (enable_toggle) men[s] = !men[s];
      end
    end
    #1;
    emask = 0;
    for (int i = 0; i < NA; i++) emask |= int'(men[i]) << i;
    cmp("hour_data", hour_data, s < NA ? bcd8(mh[s]) : 0);
    cmp("minute_data", minute_data, s < NA ? bcd8(mm[s]) : 0);
    cmp("second_data", second_data, 0);
    cmp("enabled", enabled, s < NA ? int'(men[s]) : 0);
    cmp("enable_mask", enable_mask, emask);
    cmp("ringing", ringing, int'(m_ring));
    cmp("ring_id", ring_id, m_id);
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_min(int n);
    repeat (n) begin minute_set = 1; cyc(); minute_set = 0; cyc(); end
  endtask
  task automatic pulse_hr(int n);
    repeat (n) begin hour_set = 1; cyc(); hour_set = 0; cyc(); end
  endtask
  task automatic toggle();
    enable_toggle = 1; cyc(); enable_toggle = 0; cyc();
  endtask
  task automatic tick_p();
    second_tick = 1; cyc(); second_tick = 0; cyc();
  endtask

  initial begin
    cyc(2);
    rst = 0;
    cyc();
    cmp("reset_mask", enable_mask, 0);
    cmp("reset_ring", ringing, 0);
    sel = 2'd2;
    cyc();
    for (int i = 1; i <= 60; i++) begin
      pulse_min(1);
      if (i == 1) cmp("min_first", minute_data, 8'h01);
      if (i == 59) cmp("min_59", minute_data, 8'h59);
      if (i == 60) cmp("min_wrap", minute_data, 8'h00);
    end
    cmp("hour_untouched", hour_data, 8'h00);
    pulse_hr(20);
    cmp("hour_20", hour_data, 8'h20);
    hour_set = 1;
    cyc(HD + 3 * RP + 1);
    hour_set = 0;
    cyc();
    cmp("hold_5_incs", hour_data, 8'h01);
    sel = 2'd0; pulse_hr(7); pulse_min(30);
    th_i = 7; tm_i = 30; ts_i = 0;
    tick_p();
    cmp("disabled_no_ring", ringing, 0);
    sel = 2'd1; pulse_hr(7); pulse_min(30); toggle();
    sel = 2'd3; pulse_hr(7); pulse_min(30); toggle();
    cmp("mask_1_3", enable_mask, 4'b1010);
    second_tick = 1; cyc(); second_tick = 0;
    cmp("ring_start", ringing, 1);
    cmp("ring_id_1", ring_id, 1);
    ts_i = 1;
    repeat (RT - 1) tick_p();
    cmp("ring_before_timeout", ringing, 1);
    tick_p();
    cmp("ring_timeout", ringing, 0);
    ts_i = 0;
    second_tick = 1; cyc();
    cmp("ring_again", ringing, 1);
    stop = 1; cyc(); stop = 0; second_tick = 0;
    cmp("stop_no_retrigger", ringing, 0);
    cyc();
    cmp("stop_stays_idle", ringing, 0);
    second_tick = 1; cyc(); second_tick = 0;
    cmp("ring_third", ringing, 1);
    sel = 2'd1; enable_toggle = 1; cyc(); enable_toggle = 0;
    cmp("toggle_clears", ringing, 0);
    cmp("mask_3", enable_mask, 4'b1000);
    second_tick = 1; cyc(); second_tick = 0;
    cmp("ring_id_3", ring_id, 3);
    sel = 2'd0; hour_set = 1;
    cyc(20);
    rst = 1; cyc(); rst = 0;
    cyc(3);
    cmp("rst_hour", hour_data, 8'h00);
    cmp("rst_mask", enable_mask, 0);
    cmp("rst_ring", ringing, 0);
    cmp("rst_id", ring_id, 0);
    hour_set = 0; cyc();
    pulse_hr(1);
    cmp("press_after_rst", hour_data, 8'h01);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = $urandom_range(0, 699) == 0;
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) minute_set = !minute_set;
      if ($urandom_range(0, 15) == 0) hour_set = !hour_set;
      enable_toggle = $urandom_range(0, 11) == 0;
      stop = $urandom_range(0, 19) == 0;
      second_tick = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 1) == 0) begin
        int j = $urandom_range(0, NA - 1);
        th_i = mh[j]; tm_i = mm[j];
      end else begin
        th_i = $urandom_range(0, 23); tm_i = $urandom_range(0, 59);
      end
      ts_i = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 59);
    end
    @(negedge clk);
    rst = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
